// File: rtl/perf_counter_mmio_pkg.sv
// Purpose: shared types and address constants for the performance-counter MMIO window.
// Contents: window base/offsets, CTRL register layout, request FSM state encoding.
// Imported by perf_counter_mmio and perf_ovf_detect.
package perf_counter_mmio_pkg;

  // Default window base; the window spans PERF_BASE .. PERF_BASE + PERF_WIN_LAST.
  localparam logic [15:0] PERF_BASE     = 16'hFF00;
  localparam logic [15:0] PERF_CTRL_OFF = 16'h10;
  localparam logic [15:0] PERF_STAT_OFF = 16'h12;
  localparam logic [15:0] PERF_WIN_LAST = 16'h13;

  // CTRL register bits [2:0]; declared MSB first so freeze lands on bit 0.
  typedef struct packed {
    logic clr_all;
    logic snap;
    logic freeze;
  } perf_ctrl_t;

  typedef enum logic {
    PERF_IDLE = 1'b0,
    PERF_RESP = 1'b1
  } perf_state_t;

endpackage

// File: rtl/perf_counter_mmio_ovf_detect.sv
// Purpose: per-counter wrap detector with a sticky, write-1-to-clear overflow flag.
// Ports: clk/reset; count (live counter value); cnt_reset (clear pulse sent to that counter);
//        w1c (software clear strobe); sticky (overflow flag, registered).
module perf_ovf_detect
  import perf_counter_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] count,
  input  logic        cnt_reset,
  input  logic        w1c,
  output logic        sticky
);

  logic [15:0] prev_q;
  logic        mask_q;
  logic        sticky_q;
  logic        wrap;

  // A counter that was just cleared also goes from FFFF to 0, so the cycle
  // following its clear pulse is not allowed to look like a wrap.
  assign wrap = (prev_q == 16'hFFFF) && (count == 16'h0000) && !mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= '0;
      mask_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      prev_q   <= count;
      mask_q   <= cnt_reset;
      // A new wrap takes priority over a simultaneous software clear.
      sticky_q <= wrap | (sticky_q & ~w1c);
    end
  end

  assign sticky = sticky_q;

endmodule

// File: rtl/perf_counter_mmio.sv
// Purpose: memory-mapped window exposing NUM_CNT 16-bit counters, CTRL and STATUS to the MEM stage.
// Ports: clk/reset; count_in (packed counts); mem_* request/response port (1-cycle latency,
//        request held until mem_resp); cnt_reset (per-counter clear, also asserted during reset).
module perf_counter_mmio
  import perf_counter_mmio_pkg::*;
#(
  parameter int          NUM_CNT = 8,
  parameter logic [15:0] BASE    = PERF_BASE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CNT*16-1:0]  count_in,
  input  logic [15:0]            mem_address,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [15:0]            mem_wdata,
  input  logic [1:0]             mem_byte_enable,
  output logic                   mem_resp,
  output logic [15:0]            mem_rdata,
  output logic [NUM_CNT-1:0]     cnt_reset
);

  perf_state_t        state_q, state_d;
  logic [15:0]        req_off;
  logic               sel;

  // Request captured in IDLE, consumed in RESP.
  logic [15:0]        off_q;
  logic [7:0]         wdata_q;
  logic               be0_q;
  logic               wr_q;

  logic               in_resp;
  logic               commit;
  logic               hit_cnt, hit_ctrl, hit_stat;
  logic [2:0]         cnt_idx;
  logic [NUM_CNT-1:0] cnt_sel_oh;
  logic               cnt_we, ctrl_we, stat_we;
  perf_ctrl_t         ctrl_wr;

  logic [NUM_CNT-1:0] pulse_d, pulse_q;
  logic               freeze_q;
  logic [15:0]        snap_q [NUM_CNT];
  logic [NUM_CNT-1:0] status;
  logic [15:0]        rdata;

  // Address bit 0 never selects anything; bits not needed by any register are dropped here.
  logic               unused_bits;
  assign unused_bits = ^{mem_address[0], mem_wdata[15:8], mem_byte_enable[1]};

  // Offset from the window base; the unsigned compare also rejects addresses below BASE.
  assign req_off = {mem_address[15:1], 1'b0} - BASE;
  assign sel     = (mem_read | mem_write) & (req_off <= PERF_WIN_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      PERF_IDLE: if (sel) state_d = PERF_RESP;
      PERF_RESP: state_d = PERF_IDLE;
      default:   state_d = PERF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PERF_IDLE;
      off_q   <= '0;
      wdata_q <= '0;
      be0_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == PERF_IDLE && sel) begin
        off_q   <= req_off;
        wdata_q <= mem_wdata[7:0];
        be0_q   <= mem_byte_enable[0];
        // Read+write together is handled as a write.
        wr_q    <= mem_write;
      end
    end
  end

  // Register decode on the captured offset.
  assign in_resp  = (state_q == PERF_RESP);
  assign commit   = in_resp & wr_q;
  assign cnt_idx  = off_q[3:1];
  assign hit_cnt  = (off_q < PERF_CTRL_OFF) && ({29'd0, cnt_idx} < NUM_CNT);
  assign hit_ctrl = (off_q == PERF_CTRL_OFF);
  assign hit_stat = (off_q == PERF_STAT_OFF);
  assign ctrl_wr  = perf_ctrl_t'(wdata_q[2:0]);

  assign cnt_we   = commit & hit_cnt;
  assign ctrl_we  = commit & hit_ctrl & be0_q;
  assign stat_we  = commit & hit_stat & be0_q;

  assign cnt_sel_oh = NUM_CNT'(1) << cnt_idx;
  assign pulse_d    = ({NUM_CNT{cnt_we}} & cnt_sel_oh)
                    | {NUM_CNT{ctrl_we & ctrl_wr.clr_all}};

  // Write side effects take effect on the edge that closes RESP; a reset on
  // that edge wins, so a pending write is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_q  <= '0;
      freeze_q <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= '0;
    end else begin
      pulse_q <= pulse_d;
      if (ctrl_we) freeze_q <= ctrl_wr.freeze;
      if (ctrl_we && ctrl_wr.snap) begin
        for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= count_in[16*i +: 16];
      end
    end
  end

  assign cnt_reset = pulse_q | {NUM_CNT{reset}};

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_ovf
    perf_ovf_detect u_ovf (
      .clk       (clk),
      .reset     (reset),
      .count     (count_in[16*g +: 16]),
      .cnt_reset (cnt_reset[g]),
      .w1c       (stat_we & wdata_q[g]),
      .sticky    (status[g])
    );
  end

  // Read data exists only during RESP of a pure read; everything else reads 0.
  always_comb begin
    rdata = '0;
    if (in_resp && !wr_q) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (hit_cnt && int'(cnt_idx) == i) begin
          rdata = freeze_q ? snap_q[i] : count_in[16*i +: 16];
        end
      end
      if (hit_ctrl) rdata[0] = freeze_q;
      if (hit_stat) rdata[NUM_CNT-1:0] = status;
    end
  end

  // Reset overrides an in-flight response so the requester never sees a
  // completion for an access that was dropped.
  assign mem_resp  = in_resp & ~reset;
  assign mem_rdata = reset ? 16'h0000 : rdata;

endmodule

// File: tb/tb_perf_counter_mmio.sv
module tb_perf_counter_mmio;

  localparam int N = 8;
  localparam logic [127:0] PAT = 128'hBEEF_0707_0606_0505_0042_0303_0202_1234;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*16-1:0]   count_in;
  logic [15:0]       mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_byte_enable;
  logic              mem_resp;
  logic [15:0]       mem_rdata;
  logic [N-1:0]      cnt_reset;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_counter_mmio #(.NUM_CNT(N), .BASE(16'hFF00)) dut (
    .clk             (clk),
    .reset           (reset),
    .count_in        (count_in),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .cnt_reset       (cnt_reset)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    logic [7:0]  exp_pulse;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one access and holds it until mem_resp or 4 cycles; lat=0 means no response.
  // Returns one cycle after the response with the request dropped (FSM back in IDLE).
  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] be,
                        output logic [15:0] rdata, output int lat);
    int k;
    mem_address = addr; mem_read = rd; mem_write = wr;
    mem_wdata = wd; mem_byte_enable = be;
    lat = 0; k = 0; rdata = 16'h0000;
    while (lat == 0 && k < 4) begin
      tick();
      k++;
      if (mem_resp) begin
        lat = k;
        rdata = mem_rdata;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
  endtask

  task automatic rd_chk(input string name, input logic [15:0] addr, input logic [15:0] exp);
    logic [15:0] d; int lat;
    access(1'b1, 1'b0, addr, 16'h0, 2'b11, d, lat);
    chk({name, "_lat"}, lat, 1);
    chk(name, {16'h0, d}, {16'h0, exp});
  endtask

  task automatic wr_do(input string name, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [1:0] be);
    logic [15:0] d; int lat;
    access(1'b0, 1'b1, addr, wd, be, d, lat);
    chk({name, "_lat"}, lat, 1);
  endtask

  task automatic addv(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                      input logic [1:0] be, input logic [15:0] er, input logic [7:0] ep);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.be = be;
    v.exp_rdata = er; v.exp_pulse = ep;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    int          lat;
    logic [3:0]  pat;
    logic        back2back;
    int          k;

    //       rd   wr   addr      wdata     be     rdata     pulse
    addv(1'b1, 1'b0, 16'hFF06, 16'h0000, 2'b11, 16'h0042, 8'h00); // count 3
    addv(1'b1, 1'b0, 16'hFF07, 16'h0000, 2'b11, 16'h0042, 8'h00); // bit0 ignored
    addv(1'b1, 1'b0, 16'hFF00, 16'h0000, 2'b11, 16'h1234, 8'h00); // count 0
    addv(1'b1, 1'b0, 16'hFF0E, 16'h0000, 2'b11, 16'hBEEF, 8'h00); // count 7
    addv(1'b0, 1'b1, 16'hFF04, 16'h5A5A, 2'b11, 16'h0000, 8'h04); // clear counter 2
    addv(1'b0, 1'b1, 16'hFF0E, 16'h0000, 2'b00, 16'h0000, 8'h80); // clear ignores be
    addv(1'b1, 1'b0, 16'hFF10, 16'h0000, 2'b11, 16'h0000, 8'h00); // CTRL
    addv(1'b1, 1'b0, 16'hFF13, 16'h0000, 2'b11, 16'h0000, 8'h00); // STATUS, last byte
    addv(1'b1, 1'b1, 16'hFF06, 16'h0000, 2'b11, 16'h0000, 8'h08); // rd+wr = write
    addv(1'b0, 1'b1, 16'hFF10, 16'h0004, 2'b10, 16'h0000, 8'h00); // CTRL needs be0
    addv(1'b0, 1'b1, 16'hFF10, 16'h0004, 2'b01, 16'h0000, 8'hFF); // CLR_ALL
    addv(1'b0, 1'b1, 16'hFF10, 16'h00F1, 2'b01, 16'h0000, 8'h00); // FREEZE only
    addv(1'b1, 1'b0, 16'hFF10, 16'h0000, 2'b11, 16'h0001, 8'h00);
    addv(1'b1, 1'b0, 16'hFF06, 16'h0000, 2'b11, 16'h0000, 8'h00); // frozen, snap still 0
    addv(1'b0, 1'b1, 16'hFF10, 16'h0000, 2'b11, 16'h0000, 8'h00);
    addv(1'b1, 1'b0, 16'hFF06, 16'h0000, 2'b11, 16'h0042, 8'h00); // live again
    addv(1'b1, 1'b0, 16'hFF11, 16'h0000, 2'b11, 16'h0000, 8'h00);
    addv(1'b0, 1'b1, 16'hFF12, 16'h00FF, 2'b01, 16'h0000, 8'h00); // W1C nothing set

    // Reset state
    reset = 1'b1; count_in = PAT; mem_address = 16'h0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wdata = 16'h0; mem_byte_enable = 2'b00;
    tick(); tick(); tick();
    chk("rst_resp", mem_resp, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_cnt_reset", cnt_reset, 8'hFF);
    reset = 1'b0;
    tick();
    chk("post_rst_cnt_reset", cnt_reset, 8'h00);
    chk("post_rst_resp", mem_resp, 0);

    // Table vectors
    for (int i = 0; i < vq.size(); i++) begin
      access(vq[i].rd, vq[i].wr, vq[i].addr, vq[i].wd, vq[i].be, d, lat);
      chk($sformatf("vec%0d_lat", i), lat, 1);
      chk($sformatf("vec%0d_rdata", i), d, vq[i].exp_rdata);
      chk($sformatf("vec%0d_pulse", i), cnt_reset, vq[i].exp_pulse);
      chk($sformatf("vec%0d_noresp", i), mem_resp, 0);
      tick();
      chk($sformatf("vec%0d_pulse_end", i), cnt_reset, 8'h00);
    end

    // Outside the window: no response
    access(1'b1, 1'b0, 16'hFF14, 16'h0, 2'b11, d, lat);
    chk("miss_ff14", lat, 0);
    access(1'b1, 1'b0, 16'hFEFE, 16'h0, 2'b11, d, lat);
    chk("miss_fefe", lat, 0);

    // Snapshot + freeze
    count_in[15:0] = 16'h0005;
    tick();
    wr_do("t3_ctrl3", 16'hFF10, 16'h0003, 2'b01);
    count_in[15:0] = 16'h0009;
    tick();
    rd_chk("t3_frozen0", 16'hFF00, 16'h0005);
    rd_chk("t3_frozen1", 16'hFF02, 16'h0202);
    rd_chk("t3_ctrl", 16'hFF10, 16'h0001);
    wr_do("t3_ctrl0", 16'hFF10, 16'h0000, 2'b11);
    rd_chk("t3_live0", 16'hFF00, 16'h0009);

    // Overflow detection, W1C and clear masking
    count_in[31:16] = 16'hFFFF; tick(); tick();
    count_in[31:16] = 16'h0000; tick(); tick();
    rd_chk("t4_status_set", 16'hFF12, 16'h0002);
    wr_do("t4_w1c_be1", 16'hFF12, 16'h0002, 2'b10);
    rd_chk("t4_status_kept", 16'hFF12, 16'h0002);
    wr_do("t4_w1c", 16'hFF12, 16'h0002, 2'b01);
    rd_chk("t4_status_clr", 16'hFF12, 16'h0000);
    count_in[31:16] = 16'hFFFF; tick(); tick();
    mem_address = 16'hFF02; mem_write = 1'b1; mem_wdata = 16'h0; mem_byte_enable = 2'b11;
    k = 0;
    while (!cnt_reset[1] && k < 6) begin
      tick();
      k++;
      if (mem_resp) mem_write = 1'b0;
    end
    mem_write = 1'b0;
    chk("t4_clr_pulse", cnt_reset, 8'h02);
    tick();
    count_in[31:16] = 16'h0000;   // counter obeys its clear one edge later
    tick(); tick(); tick();
    rd_chk("t4_masked", 16'hFF12, 16'h0000);

    // Held read: a response every other cycle
    mem_address = 16'hFF10; mem_read = 1'b1; pat = 4'b0; back2back = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (pat[0] && mem_resp) back2back = 1'b1;
      pat = {pat[2:0], mem_resp};
    end
    mem_read = 1'b0;
    tick(); tick();
    chk("t5_resp_pattern", pat, 4'b1010);
    chk("t5_back2back", back2back, 0);

    // Reset during RESP drops the pending write
    wr_do("t6_freeze", 16'hFF10, 16'h0001, 2'b01);
    count_in[95:80] = 16'hFFFF; tick(); tick();
    count_in[95:80] = 16'h0000; tick(); tick();
    rd_chk("t6_status", 16'hFF12, 16'h0020);
    mem_address = 16'hFF10; mem_wdata = 16'h0005; mem_byte_enable = 2'b01; mem_write = 1'b1;
    tick();
    chk("t6_in_resp", mem_resp, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_resp", mem_resp, 0);
    chk("t6_rst_cnt_reset", cnt_reset, 8'hFF);
    mem_write = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_no_clr_all", cnt_reset, 8'h00);
    tick();
    chk("t6_no_late_resp", mem_resp, 0);
    rd_chk("t6_ctrl", 16'hFF10, 16'h0000);
    rd_chk("t6_status0", 16'hFF12, 16'h0000);
    rd_chk("t6_live3", 16'hFF06, 16'h0042);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
